// File: rtl/fxp_accumulator_if.sv
// Operand and result valid/ready streams of the fixed-point accumulator.
// Handshake rule: a beat transfers on a rising clk edge where valid && ready; a
// source holds valid and its payload stable until that edge, and ready may be
// driven independently of valid.
interface fxp_accumulator_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow
  );
endinterface

// File: rtl/fxp_accumulator.sv
// Streaming signed accumulator: sums each group of COUNT operands with optional
// saturation and presents the result plus a sticky overflow flag downstream.
module fxp_accumulator #(
  parameter int N        = 32,
  parameter int COUNT    = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  fxp_accumulator_if.slave  bus,
  output logic              dbg_state_o
);
  localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t       state_q;
  logic [N-1:0] acc_q;
  logic [CW-1:0] cnt_q;
  logic         ovf_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [N-1:0] out_data_q;
  logic         out_ovf_q;

  logic [N:0]   sum;
  logic         add_ovf;
  logic [N-1:0] acc_d;
  logic         ovf_d;
  logic         xfer;
  logic         last;

  // One extra bit of headroom makes overflow visible as a sign mismatch.
  assign sum     = {acc_q[N-1], acc_q} + {bus.in_data[N-1], bus.in_data};
  assign add_ovf = sum[N] ^ sum[N-1];
  assign ovf_d   = ovf_q | add_ovf;
  assign xfer    = bus.in_valid && in_ready_q;
  assign last    = (cnt_q == CW'(COUNT - 1));

  always_comb begin
    acc_d = sum[N-1:0];
    if (SATURATE && add_ovf) begin
      acc_d = sum[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          // in_ready comes up on the first edge after reset release.
          in_ready_q <= 1'b1;
          if (xfer) begin
            if (last) begin
              out_data_q  <= acc_d;
              out_ovf_q   <= ovf_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              acc_q       <= '0;
              cnt_q       <= '0;
              ovf_q       <= 1'b0;
              state_q     <= HOLD;
            end else begin
              acc_q <= acc_d;
              ovf_q <= ovf_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_overflow = out_ovf_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_fxp_accumulator.sv
// Bench for fxp_accumulator at N=8, COUNT=4: a saturating and a wrapping
// instance share the same stimulus and are checked against a result queue.
module tb_fxp_accumulator;
  localparam int N = 8;
  localparam int W = 2 * (N + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic dbg_sat, dbg_wrap;

  fxp_accumulator_if #(.N(N)) sat_if ();
  fxp_accumulator_if #(.N(N)) wrap_if ();

  assign sat_if.in_valid   = in_valid;
  assign sat_if.in_data    = in_data;
  assign sat_if.out_ready  = out_ready;
  assign wrap_if.in_valid  = in_valid;
  assign wrap_if.in_data   = in_data;
  assign wrap_if.out_ready = out_ready;

  fxp_accumulator #(.N(N), .COUNT(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(sat_if), .dbg_state_o(dbg_sat)
  );
  fxp_accumulator #(.N(N), .COUNT(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(wrap_if), .dbg_state_o(dbg_wrap)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // scoreboard: {sat_data, sat_ovf, wrap_data, wrap_ovf}
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && !clear && out_ready && sat_if.out_valid) begin
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sat_result", {sat_if.out_data, sat_if.out_overflow}, e[W-1 -: N+1]);
        check("wrap_result", {wrap_if.out_data, wrap_if.out_overflow}, e[N:0]);
        check("wrap_valid", wrap_if.out_valid, 1'b1);
      end
    end
  end

  typedef struct {
    logic [3:0][N-1:0] d;
    logic [N-1:0]      sat_data;
    logic              sat_ovf;
    logic [N-1:0]      wrap_data;
    logic              wrap_ovf;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [N-1:0] a, b, c, e,
                         input logic [N-1:0] sd, input logic so,
                         input logic [N-1:0] wd, input logic wo);
    vec_t v;
    v.d = {e, c, b, a};
    v.sat_data = sd; v.sat_ovf = so; v.wrap_data = wd; v.wrap_ovf = wo;
    vecs.push_back(v);
  endtask

  // driver: present one operand, wait (bounded) for in_ready, transfer on an edge
  task automatic send_op(input logic [N-1:0] d);
    int budget = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!sat_if.in_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_ops(input logic [3:0][N-1:0] d);
    for (int i = 0; i < 4; i++) send_op(d[i]);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {sat_if.in_ready, sat_if.out_valid, sat_if.out_data, sat_if.out_overflow,
                 wrap_if.in_ready, wrap_if.out_valid, wrap_if.out_data, wrap_if.out_overflow},
          32'd0);
  endtask

  // full group: operands, latency check, optional hold, then one accept pulse
  task automatic run_group(input vec_t v, input int hold);
    send_ops(v.d);
    exp_q.push_back({v.sat_data, v.sat_ovf, v.wrap_data, v.wrap_ovf});
    check("latency_valid", {sat_if.out_valid, sat_if.in_ready, dbg_sat}, 3'b101);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_accept", {sat_if.out_valid, sat_if.in_ready, dbg_sat}, 3'b010);
  endtask

  vec_t tmp;

  initial begin
    add_vec(8'd1, 8'd2, 8'd3, 8'd4,         8'd10, 1'b0, 8'd10, 1'b0);
    add_vec(8'h64, 8'h64, 8'hFB, 8'h01,     8'd123, 1'b1, 8'hC4, 1'b1);
    add_vec(8'h80, 8'hFF, 8'h00, 8'h00,     8'h80, 1'b1, 8'h7F, 1'b1);
    add_vec(8'd5, 8'd5, 8'd5, 8'd5,         8'd20, 1'b0, 8'd20, 1'b0);
    add_vec(8'h7F, 8'h01, 8'hFF, 8'h81,     8'hFF, 1'b1, 8'h00, 1'b1);
    add_vec(8'h9C, 8'h9C, 8'h32, 8'h32,     8'hE4, 1'b1, 8'h9C, 1'b1);
    add_vec(8'h3C, 8'hC4, 8'h7F, 8'h80,     8'hFF, 1'b0, 8'hFF, 1'b0);
    add_vec(8'd1, 8'd1, 8'd1, 8'd1,         8'd4, 1'b0, 8'd4, 1'b0);
    add_vec(8'd2, 8'd2, 8'd2, 8'd2,         8'd8, 1'b0, 8'd8, 1'b0);

    // reset with random inputs
    repeat (4) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      clear     = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_reset_outputs("reset_outputs");
    end
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    #2 rst_n = 1'b1;
    #1 check("in_ready_before_edge", sat_if.in_ready, 1'b0);
    @(posedge clk); #1;
    check("in_ready_after_release", {sat_if.in_ready, wrap_if.in_ready}, 2'b11);
    repeat (3) begin @(posedge clk); #1; end
    check("idle_no_valid", {sat_if.out_valid, wrap_if.out_valid}, 2'b00);

    // basic sum, then back-pressure with in_valid held high in HOLD
    send_ops(vecs[0].d);
    exp_q.push_back({vecs[0].sat_data, vecs[0].sat_ovf, vecs[0].wrap_data, vecs[0].wrap_ovf});
    check("basic_latency", {sat_if.out_valid, sat_if.in_ready}, 2'b10);
    in_valid = 1'b1; in_data = 8'd99;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_stable", {sat_if.out_valid, sat_if.in_ready, sat_if.out_data}, {2'b10, 8'd10});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {sat_if.out_valid, sat_if.in_ready}, 2'b01);
    run_group(vecs[3], 0);

    // clear discards the concurrent operand and the partial group
    send_op(8'd7); send_op(8'd7);
    in_data = 8'd9; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clear_state", {sat_if.out_valid, sat_if.in_ready, dbg_sat}, 3'b010);
    run_group(vecs[7], 1);

    // clear while a result is held
    tmp = vecs[0];
    send_ops(tmp.d);
    check("hold_before_clear", sat_if.out_valid, 1'b1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_in_hold", {sat_if.out_valid, wrap_if.out_valid, sat_if.in_ready}, 3'b001);

    // reset mid-frame, then a clean group
    send_op(8'd2); send_op(8'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_frame");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_group(vecs[8], 0);

    // table of overflow and sign patterns with random hold times
    for (int i = 1; i < 7; i++) run_group(vecs[i], $urandom_range(0, 3));

    repeat (2) begin @(posedge clk); #1; end
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
